cic_port: RTL and testbench
===========================

CIC_PORT -- requirements
Module: cic_port

Interface
REQ-001 SHALL have ports: clk  in  1  master clock; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: xmt  in  1  0=receive, 1=transmit; c  in  1  channel count (0=one, 1=two); rate  in  12  decimation/interpolation factor.
REQ-003 SHALL have filter-side ports: cea, ceb  out  1  channel strobes; tiea, tieb  in  1  TX sample requests; tdi  out  18  TX sample; rdo  in  18  RX sample; rova, rovb  in  1  RX valid; ovfa, ovfb  in  1  RX overflow.
REQ-004 SHALL have RX stream ports: rx_data  out  18; rx_ch  out  1; rx_ovf  out  1; rx_valid  out  1; rx_ready  in  1.
REQ-005 SHALL have TX stream ports: tx_data  in  18; tx_ch  in  1; tx_valid  in  1; tx_ready  out  1.
REQ-006 SHALL have status ports: rx_lost  out  1  sticky; tx_under  out  1  sticky; stat_clr  in  1  clears stickies.

Function
REQ-007 Rate counter SHALL count 0..R-1 and wrap, where R = max(rate, 8).
- cea pulses one cycle when count = R-1.
- ceb pulses on the following cycle when c=1; it stays 0 when c=0.
REQ-008 A change of rate SHALL take effect only at the next wrap; the current period completes unchanged.
REQ-009 A change of xmt or c, sampled registered, SHALL restart the counter at 0, flush the RX FIFO and invalidate both TX holding registers in the same cycle.
REQ-010 RX: a cycle with rova=1 or rovb=1 SHALL write {ch, ovf, rdo} into a 4-entry FIFO.
- ch = rovb; ovf = ovfb when ch=1, otherwise ovfa.
- rova and rovb both high in one cycle: channel A is written, channel B is dropped and rx_lost is set.
REQ-011 An RX write when the FIFO is full SHALL be dropped and SHALL set rx_lost; FIFO contents are unchanged.
REQ-012 The RX stream SHALL present the FIFO head with valid/ready semantics.
- Pop occurs when rx_valid & rx_ready.
- Simultaneous push and pop when full SHALL succeed with no loss.
- The first-word latency from rov to rx_valid is 1 cycle.
REQ-013 TX SHALL hold one holding register plus a valid bit per channel.
- tx_ready = ~valid[tx_ch].
- tx_ch=1 while c=0: tx_ready=0.
- tx_valid & tx_ready loads tx_data into the register.
REQ-014 On the cycle cea (or ceb) asserts with xmt=1:
- tdi is registered from channel A (or B) holding and that valid bit is cleared.
- If the holding register is empty, tdi is set to 0 and tx_under is set.
- tdi is held until the next load, so it is stable when tiea/tieb asserts 2 cycles later.
REQ-015 With xmt=0, tdi SHALL be 0 and tx_ready SHALL be 0; with xmt=1, RX writes SHALL be ignored.
REQ-016 A holding-register load and a drain of the same channel in the same cycle SHALL drain the old value first, then load the new one; the register stays valid.
REQ-017 stat_clr SHALL clear rx_lost and tx_under; a new set event in the same cycle SHALL win.

Reset
REQ-018 While rst=0, all state SHALL clear asynchronously: counter=0, cea=ceb=0, tdi=0, FIFO empty, rx_valid=0, rx_data=0, rx_ch=0, rx_ovf=0, holding registers invalid, tx_ready=0, rx_lost=0, tx_under=0.
REQ-019 After rst releases, the first cea SHALL occur R cycles later.
REQ-020 Reset asserted mid-operation SHALL discard all FIFO and holding contents without emitting partial samples.

Configuration
REQ-021 With macro CIC_PORT_STATS_EN defined:
- 16-bit saturating counters rx_lost_cnt and tx_under_cnt SHALL be added as outputs.
- Each counter increments once per event and is cleared by stat_clr or reset.
- Without the macro, these ports and counters are absent and the rest of the behaviour is identical.

Structure
REQ-022 Package cic_pkg SHALL hold: SAMPLE_W=18, RATE_W=12, RATE_MIN=8, RXQ_DEPTH=4, and the RX entry typedef {ch, ovf, data}.
REQ-023 The RX queue SHALL be a sub-module cic_fifo (parameterised width/depth, full/empty, simultaneous push/pop).

Verification
REQ-024 rate=16, c=1, xmt=0: cea at cycles 16, 32, …; ceb at cycles 17, 33, …; rate=3 gives period 8.
REQ-025 Inject rova with rdo=0x1234 and ovfa=1, with rx_ready=1: the next cycle shows rx_valid=1, rx_data=0x1234, rx_ch=0, rx_ovf=1.
REQ-026 rx_ready=0 with 5 RX samples: 4 are queued, rx_lost=1, and drained order is samples 1-4 in sequence.
REQ-027 xmt=1, load channel A with 0x2AAAA, then wait for cea: tdi=0x2AAAA the following cycle; at the next cea with no load, tdi=0 and tx_under=1.
REQ-028 Change rate from 16 to 8 at count 5: the current period ends at 16 and the next period is 8; toggling xmt mid-period restarts the count and flushes the queues.
REQ-029 Assert rst with 3 RX entries queued: rx_valid drops immediately and is 0 after release.

Source files
------------

// File: rtl/cic_pkg.sv
// CIC port shared definitions: widths, queue depth, RX entry layout and
// small arithmetic helpers used by the port and its RX queue.
package cic_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int RATE_W    = 12;
  localparam int RATE_MIN  = 8;
  localparam int RXQ_DEPTH = 4;

  // One queued RX sample: channel, overflow flag and sample word.
  typedef struct packed {
    logic                ch;
    logic                ovf;
    logic [SAMPLE_W-1:0] data;
  } rx_entry_t;

  // Effective period: rates below the minimum are clamped up to it.
  function automatic logic [RATE_W-1:0] rate_eff(input logic [RATE_W-1:0] r);
    if (r < RATE_W'(RATE_MIN)) begin
      return RATE_W'(RATE_MIN);
    end else begin
      return r;
    end
  endfunction

  // 16-bit saturating increment by 0..3.
  function automatic logic [15:0] sat_inc16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/cic_fifo.sv
// Small synchronous FIFO with full/empty flags, flush and simultaneous
// push/pop (a push into a full queue succeeds when a pop happens the same
// cycle). Output word is forced to zero while the queue is empty.
module cic_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_r;
  logic [AW-1:0] rd_r;
  logic [CW-1:0] cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (cnt_r == CNT_ZERO);
  assign full      = (cnt_r == CNT_FULL);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = empty ? {W{1'b0}} : mem_r[rd_r];

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_r  <= PTR_ZERO;
      rd_r  <= PTR_ZERO;
      cnt_r <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      wr_r  <= PTR_ZERO;
      rd_r  <= PTR_ZERO;
      cnt_r <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_r] <= din;
        wr_r        <= (wr_r == PTR_LAST) ? PTR_ZERO : wr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_r <= (rd_r == PTR_LAST) ? PTR_ZERO : rd_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/cic_port.sv
// CIC filter port: generates channel strobes from a rate counter, queues
// RX samples from the filter into a stream, and feeds TX samples from
// per-channel holding registers into the filter.
// Optional feature macro: CIC_PORT_STATS_EN adds saturating event counters
// rx_lost_cnt and tx_under_cnt.
module cic_port
  import cic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                xmt,
  input  logic                c,
  input  logic [RATE_W-1:0]   rate,
  output logic                cea,
  output logic                ceb,
  input  logic                tiea,
  input  logic                tieb,
  output logic [SAMPLE_W-1:0] tdi,
  input  logic [SAMPLE_W-1:0] rdo,
  input  logic                rova,
  input  logic                rovb,
  input  logic                ovfa,
  input  logic                ovfb,
  output logic [SAMPLE_W-1:0] rx_data,
  output logic                rx_ch,
  output logic                rx_ovf,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [SAMPLE_W-1:0] tx_data,
  input  logic                tx_ch,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                rx_lost,
  output logic                tx_under,
  input  logic                stat_clr
`ifdef CIC_PORT_STATS_EN
  ,
  output logic [15:0]         rx_lost_cnt,
  output logic [15:0]         tx_under_cnt
`endif
);

  localparam logic [SAMPLE_W-1:0] ZERO_SMP = {SAMPLE_W{1'b0}};
  localparam logic [RATE_W-1:0]   ZERO_CNT = {RATE_W{1'b0}};
  localparam logic [RATE_W-1:0]   ONE_CNT  = RATE_W'(1);

  logic                start_r;
  logic                xmt_r;
  logic                c_r;
  logic [RATE_W-1:0]   cnt_r;
  logic [RATE_W-1:0]   per_r;
  logic [RATE_W-1:0]   per_s;
  logic                wrap_s;
  logic                chg_s;
  logic                cea_r;
  logic                ceb_r;

  logic                rx_en_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  rx_entry_t           rx_in_s;
  rx_entry_t           rx_out_s;
  logic                lost_a_s;
  logic                lost_b_s;
  logic                rx_lost_r;

  logic [SAMPLE_W-1:0] hold_a_r;
  logic [SAMPLE_W-1:0] hold_b_r;
  logic [1:0]          val_r;
  logic [SAMPLE_W-1:0] tdi_r;
  logic                tx_ready_s;
  logic                ld_a_s;
  logic                ld_b_s;
  logic                dr_a_s;
  logic                dr_b_s;
  logic                under_ev_s;
  logic                tx_under_r;

  // The filter's sample requests need no action: tdi is already stable when they arrive.
  logic                unused_tie_s;
  assign unused_tie_s = tiea ^ tieb;

  // Period in force: the live rate until the first edge after reset, then the latched one.
  always_comb begin
    if (start_r) begin
      per_s = per_r;
    end else begin
      per_s = rate_eff(rate);
    end
  end

  assign wrap_s = (cnt_r == per_s - ONE_CNT);
  assign chg_s  = start_r & ((xmt ^ xmt_r) | (c ^ c_r));

  // Rate counter, mode capture and channel strobes; rate is latched only at wrap or restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r <= 1'b0;
      xmt_r   <= 1'b0;
      c_r     <= 1'b0;
      cnt_r   <= ZERO_CNT;
      per_r   <= ZERO_CNT;
      cea_r   <= 1'b0;
      ceb_r   <= 1'b0;
    end else begin
      start_r <= 1'b1;
      xmt_r   <= xmt;
      c_r     <= c;
      if (chg_s) begin
        cnt_r <= ZERO_CNT;
        per_r <= rate_eff(rate);
        cea_r <= 1'b0;
        ceb_r <= 1'b0;
      end else begin
        cea_r <= wrap_s;
        ceb_r <= cea_r & c_r;
        if (wrap_s || !start_r) begin
          per_r <= rate_eff(rate);
        end
        if (wrap_s) begin
          cnt_r <= ZERO_CNT;
        end else begin
          cnt_r <= cnt_r + ONE_CNT;
        end
      end
    end
  end

  assign cea = cea_r;
  assign ceb = ceb_r;

  // RX entry: channel A wins when both channels report in the same cycle.
  always_comb begin
    rx_in_s.ch   = rovb & ~rova;
    rx_in_s.ovf  = (rovb & ~rova) ? ovfb : ovfa;
    rx_in_s.data = rdo;
  end

  assign rx_en_s  = start_r & ~xmt_r & ~chg_s;
  assign push_s   = rx_en_s & (rova | rovb);
  assign pop_s    = rx_valid & rx_ready;
  assign lost_a_s = push_s & fifo_full_s & ~pop_s;
  assign lost_b_s = rx_en_s & rova & rovb;

  cic_fifo #(
    .W     ($bits(rx_entry_t)),
    .DEPTH (RXQ_DEPTH)
  ) u_rxq (
    .clk   (clk),
    .rst   (rst),
    .flush (chg_s),
    .push  (push_s),
    .din   (rx_in_s),
    .pop   (pop_s),
    .dout  (rx_out_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rx_valid = ~fifo_empty_s;
  assign rx_data  = rx_out_s.data;
  assign rx_ch    = rx_out_s.ch;
  assign rx_ovf   = rx_out_s.ovf;

  // TX acceptance: only in transmit mode, never during a mode change, B only with two channels.
  always_comb begin
    if (xmt_r && !chg_s) begin
      if (tx_ch) begin
        tx_ready_s = c_r & ~val_r[1];
      end else begin
        tx_ready_s = ~val_r[0];
      end
    end else begin
      tx_ready_s = 1'b0;
    end
  end

  assign tx_ready   = tx_ready_s;
  assign ld_a_s     = tx_valid & tx_ready_s & ~tx_ch;
  assign ld_b_s     = tx_valid & tx_ready_s & tx_ch;
  assign dr_a_s     = cea_r & xmt_r & ~chg_s;
  assign dr_b_s     = ceb_r & xmt_r & ~chg_s;
  assign under_ev_s = (dr_a_s & ~val_r[0]) | (dr_b_s & ~val_r[1]);

  // Holding registers and tdi: a drain reads the old value before a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_a_r <= ZERO_SMP;
      hold_b_r <= ZERO_SMP;
      val_r    <= 2'b00;
      tdi_r    <= ZERO_SMP;
    end else if (chg_s) begin
      val_r <= 2'b00;
      tdi_r <= ZERO_SMP;
    end else begin
      if (!xmt_r) begin
        tdi_r <= ZERO_SMP;
      end else if (dr_a_s) begin
        tdi_r <= val_r[0] ? hold_a_r : ZERO_SMP;
      end else if (dr_b_s) begin
        tdi_r <= val_r[1] ? hold_b_r : ZERO_SMP;
      end else begin
        tdi_r <= tdi_r;
      end
      if (ld_a_s) begin
        hold_a_r <= tx_data;
        val_r[0] <= 1'b1;
      end else if (dr_a_s) begin
        val_r[0] <= 1'b0;
      end
      if (ld_b_s) begin
        hold_b_r <= tx_data;
        val_r[1] <= 1'b1;
      end else if (dr_b_s) begin
        val_r[1] <= 1'b0;
      end
    end
  end

  assign tdi = tdi_r;

  // Sticky status flags: a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_lost_r  <= 1'b0;
      tx_under_r <= 1'b0;
    end else begin
      if (lost_a_s || lost_b_s) begin
        rx_lost_r <= 1'b1;
      end else if (stat_clr) begin
        rx_lost_r <= 1'b0;
      end
      if (under_ev_s) begin
        tx_under_r <= 1'b1;
      end else if (stat_clr) begin
        tx_under_r <= 1'b0;
      end
    end
  end

  assign rx_lost  = rx_lost_r;
  assign tx_under = tx_under_r;

`ifdef CIC_PORT_STATS_EN
  logic [15:0] rx_lost_cnt_r;
  logic [15:0] tx_under_cnt_r;
  logic [1:0]  lost_inc_s;
  logic [1:0]  under_inc_s;

  assign lost_inc_s  = {1'b0, lost_a_s} + {1'b0, lost_b_s};
  assign under_inc_s = {1'b0, under_ev_s};

  // Saturating event counters; clear restarts from zero plus any same-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_lost_cnt_r  <= 16'd0;
      tx_under_cnt_r <= 16'd0;
    end else if (stat_clr) begin
      rx_lost_cnt_r  <= sat_inc16(16'd0, lost_inc_s);
      tx_under_cnt_r <= sat_inc16(16'd0, under_inc_s);
    end else begin
      rx_lost_cnt_r  <= sat_inc16(rx_lost_cnt_r, lost_inc_s);
      tx_under_cnt_r <= sat_inc16(tx_under_cnt_r, under_inc_s);
    end
  end

  assign rx_lost_cnt  = rx_lost_cnt_r;
  assign tx_under_cnt = tx_under_cnt_r;
`endif

endmodule

// File: tb/tb_cic_port.sv
// Bench for cic_port: directed scenarios plus randomized traffic, every
// cycle compared against an event-level reference model.
module tb_cic_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        xmt;
  logic        c;
  logic [11:0] rate;
  logic        cea;
  logic        ceb;
  logic        tiea;
  logic        tieb;
  logic [17:0] tdi;
  logic [17:0] rdo;
  logic        rova;
  logic        rovb;
  logic        ovfa;
  logic        ovfb;
  logic [17:0] rx_data;
  logic        rx_ch;
  logic        rx_ovf;
  logic        rx_valid;
  logic        rx_ready;
  logic [17:0] tx_data;
  logic        tx_ch;
  logic        tx_valid;
  logic        tx_ready;
  logic        rx_lost;
  logic        tx_under;
  logic        stat_clr;

  int n_err = 0;
  int n_chk = 0;

  cic_port dut (
    .clk(clk), .rst(rst), .xmt(xmt), .c(c), .rate(rate),
    .cea(cea), .ceb(ceb), .tiea(tiea), .tieb(tieb), .tdi(tdi),
    .rdo(rdo), .rova(rova), .rovb(rovb), .ovfa(ovfa), .ovfb(ovfb),
    .rx_data(rx_data), .rx_ch(rx_ch), .rx_ovf(rx_ovf),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_ch(tx_ch), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_lost(rx_lost), .tx_under(tx_under), .stat_clr(stat_clr)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    bit          ch;
    bit          ovf;
    logic [17:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_started;
  bit          m_xmt;
  bit          m_c;
  bit          m_cea;
  bit          m_ceb;
  bit          m_lost;
  bit          m_under;
  int          m_k;
  int          m_next;
  logic [17:0] m_tdi;
  logic [17:0] m_hold [2];
  bit          m_hv [2];

  function automatic int eff(input int r);
    return (r < 8) ? 8 : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_started = 0; m_xmt = 0; m_c = 0; m_cea = 0; m_ceb = 0;
    m_lost = 0; m_under = 0; m_k = 0; m_next = 0; m_tdi = 18'd0;
    m_hold[0] = 18'd0; m_hold[1] = 18'd0; m_hv[0] = 0; m_hv[1] = 0;
  endtask

  task automatic idle_inputs();
    rdo = 18'd0; rova = 1'b0; rovb = 1'b0; ovfa = 1'b0; ovfb = 1'b0;
    rx_ready = 1'b0; tx_data = 18'd0; tx_ch = 1'b0; tx_valid = 1'b0;
    stat_clr = 1'b0; tiea = 1'b0; tieb = 1'b0;
  endtask

  task automatic check_outputs();
    chk("cea", 32'(cea), 32'(m_cea));
    chk("ceb", 32'(ceb), 32'(m_ceb));
    chk("tdi", 32'(tdi), 32'(m_tdi));
    chk("rx_valid", 32'(rx_valid), 32'(m_q.size() > 0));
    chk("rx_data", 32'(rx_data), 32'((m_q.size() > 0) ? m_q[0].data : 18'd0));
    chk("rx_ch", 32'(rx_ch), 32'((m_q.size() > 0) ? m_q[0].ch : 1'b0));
    chk("rx_ovf", 32'(rx_ovf), 32'((m_q.size() > 0) ? m_q[0].ovf : 1'b0));
    chk("rx_lost", 32'(rx_lost), 32'(m_lost));
    chk("tx_under", 32'(tx_under), 32'(m_under));
  endtask

  // One clock: check ready with settled inputs, advance the model, check outputs.
  task automatic step();
    bit   chg, rdy, lost_ev, under_ev, cea_n, ceb_n;
    ent_t e;
    @(negedge clk);
    chg = m_started && ((xmt != m_xmt) || (c != m_c));
    rdy = m_xmt && !chg && (tx_ch ? (m_c && !m_hv[1]) : !m_hv[0]);
    chk("tx_ready", 32'(tx_ready), 32'(rdy));
    lost_ev = 0; under_ev = 0; cea_n = 0; ceb_n = 0;
    if (!m_started) begin
      m_k = 1;
      m_next = eff(int'(rate));
    end else if (chg) begin
      m_k = 0;
      m_next = eff(int'(rate));
      m_q.delete();
      m_hv[0] = 0; m_hv[1] = 0;
      m_tdi = 18'd0;
    end else begin
      m_k++;
      ceb_n = m_cea && m_c;
      cea_n = (m_k == m_next);
      if (cea_n) m_next += eff(int'(rate));
      if (m_q.size() > 0 && rx_ready) void'(m_q.pop_front());
      if (!m_xmt && (rova || rovb)) begin
        e.ch = rovb && !rova;
        e.ovf = e.ch ? ovfb : ovfa;
        e.data = rdo;
        if (m_q.size() < 4) m_q.push_back(e);
        else lost_ev = 1;
        if (rova && rovb) lost_ev = 1;
      end
      if (!m_xmt) begin
        m_tdi = 18'd0;
      end else if (m_cea || m_ceb) begin
        int ch;
        ch = m_cea ? 0 : 1;
        if (m_hv[ch]) begin
          m_tdi = m_hold[ch];
          m_hv[ch] = 0;
        end else begin
          m_tdi = 18'd0;
          under_ev = 1;
        end
      end
      if (rdy && tx_valid) begin
        m_hold[tx_ch] = tx_data;
        m_hv[tx_ch] = 1;
      end
    end
    m_cea = cea_n;
    m_ceb = ceb_n;
    if (lost_ev) m_lost = 1; else if (stat_clr) m_lost = 0;
    if (under_ev) m_under = 1; else if (stat_clr) m_under = 0;
    m_xmt = xmt;
    m_c = c;
    m_started = 1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_cea", 32'(cea), 32'd0);
    chk("rst_ceb", 32'(ceb), 32'd0);
    chk("rst_tdi", 32'(tdi), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_ch", 32'(rx_ch), 32'd0);
    chk("rst_rx_ovf", 32'(rx_ovf), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_lost", 32'(rx_lost), 32'd0);
    chk("rst_tx_under", 32'(tx_under), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int          rates [5];
    bit          found;
    rates[0] = 3; rates[1] = 8; rates[2] = 11; rates[3] = 16; rates[4] = 24;
    idle_inputs();
    xmt = 1'b0; c = 1'b1; rate = 12'd16;
    do_reset();

    // Strobe timing at rate 16, then rate 3 clamps to period 8.
    for (int i = 1; i <= 80; i++) begin
      if (i == 41) rate = 12'd3;
      step();
      if (i == 16 || i == 32) chk("cea_rate16", 32'(cea), 32'd1);
      if (i == 17 || i == 33) chk("ceb_rate16", 32'(ceb), 32'd1);
      if (i == 56 || i == 64) chk("cea_rate3", 32'(cea), 32'd1);
    end

    // Single RX sample with 1-cycle latency.
    rx_ready = 1'b1; rova = 1'b1; rdo = 18'h1234; ovfa = 1'b1;
    step();
    chk("rx1_valid", 32'(rx_valid), 32'd1);
    chk("rx1_data", 32'(rx_data), 32'h1234);
    chk("rx1_ch", 32'(rx_ch), 32'd0);
    chk("rx1_ovf", 32'(rx_ovf), 32'd1);
    idle_inputs(); rx_ready = 1'b1;
    step();

    // Overfill: five samples into four slots, then drain in order.
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rova = 1'b1; rdo = 18'(101 + i);
      step();
    end
    rova = 1'b0;
    step();
    chk("ovfl_lost", 32'(rx_lost), 32'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(rx_data), 32'(101 + i));
      step();
    end
    chk("drain_empty", 32'(rx_valid), 32'd0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;

    // Transmit one sample on channel A, then underflow at the next strobe.
    xmt = 1'b1; c = 1'b0; rate = 12'd16;
    step();
    tx_valid = 1'b1; tx_ch = 1'b0; tx_data = 18'h2AAAA;
    step();
    tx_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cea === 1'b1) found = 1;
    end
    chk("cea_seen_1", 32'(found), 32'd1);
    step();
    chk("tdi_loaded", 32'(tdi), 32'h2AAAA);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cea === 1'b1) found = 1;
    end
    chk("cea_seen_2", 32'(found), 32'd1);
    step();
    chk("tdi_under", 32'(tdi), 32'd0);
    chk("under_set", 32'(tx_under), 32'd1);

    // Rate change mid-period, then mode toggle flushes the queue.
    xmt = 1'b0; c = 1'b1; rate = 12'd16;
    step();
    for (int i = 1; i <= 30; i++) begin
      if (i == 6) rate = 12'd8;
      step();
      if (i == 16 || i == 24) chk("cea_rate_change", 32'(cea), 32'd1);
      if (i == 8) chk("cea_not_early", 32'(cea), 32'd0);
    end
    rx_ready = 1'b0; rova = 1'b1; rdo = 18'h00055;
    step(); step();
    rova = 1'b0;
    chk("pre_flush_valid", 32'(rx_valid), 32'd1);
    xmt = 1'b1;
    step();
    chk("flush_valid", 32'(rx_valid), 32'd0);

    // Randomized traffic with occasional mode and rate changes.
    for (int i = 0; i < 1500; i++) begin
      if (i % 90 == 0) begin
        xmt = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        rate = 12'(rates[$urandom_range(0, 4)]);
      end else if (i % 37 == 0) begin
        rate = 12'(rates[$urandom_range(0, 4)]);
      end
      rova = ($urandom_range(0, 3) == 0);
      rovb = ($urandom_range(0, 4) == 0);
      ovfa = 1'($urandom_range(0, 1));
      ovfb = 1'($urandom_range(0, 1));
      rdo = 18'($urandom);
      rx_ready = ($urandom_range(0, 2) != 0);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_ch = 1'($urandom_range(0, 1));
      tx_data = 18'($urandom);
      stat_clr = ($urandom_range(0, 19) == 0);
      step();
    end

    // Reset with three samples queued.
    idle_inputs();
    xmt = 1'b0; c = 1'b0; rate = 12'd8;
    step();
    for (int i = 0; i < 3; i++) begin
      rova = 1'b1; rdo = 18'(200 + i);
      step();
    end
    rova = 1'b0;
    chk("queued_before_rst", 32'(rx_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
    end
    chk("post_rst_valid", 32'(rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
